// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch front-end. Reads the external program counter, issues
//   memory reads at that address, steps the pc once per fetched word and
//   loads it on a branch redirect. Fetched words are buffered together with
//   their addresses in a small FIFO toward the decode stage.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   pc_value       current pc output
//   pc_inc         step the pc (one pulse per buffered word)
//   pc_load        load the pc from pc_in (branch redirect)
//   pc_in          pc load value, always redirect_addr
//   mem_req        memory read request
//   mem_addr       memory read address, held while a request is outstanding
//   mem_ack        memory read done, mem_rdata valid this cycle
//   mem_rdata      memory read data
//   instr_valid    FIFO head valid
//   instr_data     FIFO head instruction word
//   instr_addr     address of FIFO head word
//   instr_ready    decoder accepts the head word
//   redirect       one-cycle branch pulse
//   redirect_addr  branch target
module fetch_unit #(
    parameter int BUS_WIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  pc_value,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic [BUS_WIDTH-1:0]  pc_in,
    output logic                  mem_req,
    output logic [BUS_WIDTH-1:0]  mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [BUS_WIDTH-1:0]  instr_addr,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [BUS_WIDTH-1:0]  redirect_addr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    typedef enum logic [1:0] {
        S_ISSUE   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                r_state;
    logic [BUS_WIDTH-1:0]  r_addrQ;
    logic [DATA_WIDTH-1:0] r_fifoData [DEPTH];
    logic [BUS_WIDTH-1:0]  r_fifoAddr [DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_count;

    logic w_notFull;
    logic w_issue;
    logic w_push;
    logic w_pop;

    // Fullness looks at the registered count only, so a word leaving the
    // FIFO this cycle never makes room for a new request in the same cycle.
    assign w_notFull = (r_count < FULL_COUNT);

    // A new request starts only from ISSUE; a redirect suppresses it because
    // the pc is being reloaded and pc_value is stale.
    assign w_issue = reset && (r_state == S_ISSUE) && w_notFull && !redirect;

    // Data is kept only for a request that is not being redirected away;
    // DISCARD never pushes since its data belongs to the old path.
    assign w_push = reset && !redirect && mem_ack &&
                    (w_issue || (r_state == S_WAIT));
    assign w_pop  = instr_valid && instr_ready;

    // An outstanding request (WAIT or DISCARD) is never aborted, even
    // across a redirect; all outputs are forced quiet while in reset.
    assign mem_req  = w_issue || (reset && (r_state != S_ISSUE));
    assign mem_addr = (r_state == S_ISSUE) ? pc_value : r_addrQ;

    assign pc_inc  = w_push;
    assign pc_load = reset && redirect;
    assign pc_in   = redirect_addr;

    assign instr_valid = (r_count != '0);
    assign instr_data  = r_fifoData[r_rdPtr];
    assign instr_addr  = r_fifoAddr[r_rdPtr];

    // Request sequencing. A same-cycle ack in ISSUE completes the fetch
    // immediately; otherwise the address is held in r_addrQ until the ack.
    // A redirect while waiting turns the pending read into one whose data
    // will be thrown away.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_ISSUE;
            r_addrQ <= '0;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    if (w_issue) begin
                        r_addrQ <= pc_value;
                        if (!mem_ack) begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_state <= S_ISSUE;
                    end else if (redirect) begin
                        r_state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (mem_ack) begin
                        r_state <= S_ISSUE;
                    end
                end
                default: r_state <= S_ISSUE;
            endcase
        end
    end

    // FIFO bookkeeping. A redirect flushes everything at the edge, taking
    // priority over any push or pop in that cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage needs no reset; entries are only read when counted valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifoData[r_wrPtr] <= mem_rdata;
            r_fifoAddr[r_wrPtr] <= mem_addr;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int BW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic [BW-1:0] pc_value;
   logic          pc_inc;
   logic          pc_load;
   logic [BW-1:0] pc_in;
   logic          mem_req;
   logic [BW-1:0] mem_addr;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          instr_valid;
   logic [DW-1:0] instr_data;
   logic [BW-1:0] instr_addr;
   logic          instr_ready;
   logic          redirect;
   logic [BW-1:0] redirect_addr;

   int checkCount = 0;
   int failCount  = 0;

   // Environment and reference model state. The program is a stream of
   // consecutive addresses starting at the last redirect target, each word
   // holding address+100. occ is how many stream words should be buffered.
   logic [BW-1:0] pcModel  = '0;
   logic [BW-1:0] expNext  = '0;
   int            occ      = 0;
   bit            pending  = 1'b0;
   bit            dropFlag = 1'b0;
   int            remaining = 0;
   logic [BW-1:0] lockAddr = '0;
   int            forceLat = -1;
   int            maxLat   = 3;
   bit            strayAck = 1'b0;

   fetch_unit #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clock(clock),
      .reset(reset),
      .pc_value(pc_value),
      .pc_inc(pc_inc),
      .pc_load(pc_load),
      .pc_in(pc_in),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata),
      .instr_valid(instr_valid),
      .instr_data(instr_data),
      .instr_addr(instr_addr),
      .instr_ready(instr_ready),
      .redirect(redirect),
      .redirect_addr(redirect_addr)
   );

   always #5 clock = ~clock;

   // Hard stop in case something above never returns.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Reset is asserted mid-cycle and checked immediately, with redirect and
   // ack both high to show the outputs are forced quiet. Release happens just
   // after a rising edge so the model restarts cleanly at the next cycle.
   task automatic applyReset();
      @(negedge clock);
      #1;
      reset    = 1'b0;
      redirect = 1'b1;
      mem_ack  = 1'b1;
      #1;
      checkOutput("rstMemReq", 32'(mem_req), 32'd0);
      checkOutput("rstValid", 32'(instr_valid), 32'd0);
      checkOutput("rstPcInc", 32'(pc_inc), 32'd0);
      checkOutput("rstPcLoad", 32'(pc_load), 32'd0);
      redirect = 1'b0;
      mem_ack  = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      pc_value = pcModel;
      reset    = 1'b1;
      occ      = 0;
      pending  = 1'b0;
      dropFlag = 1'b0;
      expNext  = pcModel;
   endtask

   // One clock cycle: drive inputs, let the memory model answer, check the
   // combinational outputs against the stream model, then advance the model.
   task automatic applyStimulus(input logic ready, input logic redir,
                                input logic [BW-1:0] raddr);
      bit            realAck;
      bit            popM;
      bit            expInc;
      logic [DW-1:0] expData;
      @(negedge clock);
      pc_value      = pcModel;
      instr_ready   = ready;
      redirect      = redir;
      redirect_addr = raddr;
      mem_ack       = 1'b0;
      #1;
      if (!pending) begin
         checkOutput("issueReq", 32'(mem_req), 32'(occ < DEPTH && !redir));
         if (mem_req) begin
            checkOutput("issueAddr", 32'(mem_addr), 32'(pcModel));
            pending   = 1'b1;
            lockAddr  = mem_addr;
            remaining = (forceLat >= 0) ? forceLat : int'($urandom_range(0, maxLat));
         end
      end else begin
         checkOutput("reqHeld", 32'(mem_req), 32'd1);
         checkOutput("addrHeld", 32'(mem_addr), 32'(lockAddr));
      end
      realAck = pending && (remaining == 0);
      if (pending && !realAck) remaining--;
      mem_ack   = realAck || strayAck;
      mem_rdata = realAck ? (lockAddr + 16'd100) : 16'($urandom);
      #1;
      expInc = realAck && !redir && !dropFlag;
      checkOutput("pcInc", 32'(pc_inc), 32'(expInc));
      checkOutput("pcLoad", 32'(pc_load), 32'(redir));
      checkOutput("incLoadExcl", 32'(pc_inc && pc_load), 32'd0);
      if (redir) checkOutput("pcIn", 32'(pc_in), 32'(raddr));
      checkOutput("valid", 32'(instr_valid), 32'(occ != 0));
      popM = (occ != 0) && ready;
      if (popM) begin
         expData = expNext + 16'd100;
         checkOutput("instrAddr", 32'(instr_addr), 32'(expNext));
         checkOutput("instrData", 32'(instr_data), 32'(expData));
      end
      if (realAck) begin
         pending  = 1'b0;
         dropFlag = 1'b0;
      end else if (redir && pending) begin
         dropFlag = 1'b1;
      end
      if (popM) begin
         expNext = expNext + 16'd1;
         occ--;
      end
      if (expInc) occ++;
      if (redir) begin
         occ     = 0;
         expNext = raddr;
      end
      if (pc_load) pcModel = pc_in;
      else if (pc_inc) pcModel = pcModel + 16'd1;
   endtask

   initial begin
      reset         = 1'b0;
      pc_value      = '0;
      mem_ack       = 1'b0;
      mem_rdata     = '0;
      instr_ready   = 1'b0;
      redirect      = 1'b0;
      redirect_addr = '0;
      applyReset();

      // Reset in the middle of a slow read, then resume at pc_value.
      forceLat = 3;
      applyStimulus(1'b1, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, '0);
      applyReset();
      repeat (6) applyStimulus(1'b1, 1'b0, '0);

      // Streaming from address 0 with a zero-latency memory.
      forceLat = 0;
      applyStimulus(1'b1, 1'b1, 16'd0);
      repeat (6) applyStimulus(1'b1, 1'b0, '0);

      // Decoder stalled: FIFO fills, fetch stops, then resumes losslessly.
      repeat (5) applyStimulus(1'b0, 1'b0, '0);
      repeat (6) applyStimulus(1'b1, 1'b0, '0);

      // Slow memory: request and address hold until the ack.
      forceLat = 3;
      repeat (10) applyStimulus(1'b1, 1'b0, '0);

      // Redirect to 511 while a read is outstanding.
      for (int i = 0; i < 8; i++) begin
         if (pending && remaining > 0) break;
         applyStimulus(1'b1, 1'b0, '0);
      end
      checkOutput("reachWait", 32'(pending && remaining > 0), 32'd1);
      applyStimulus(1'b1, 1'b1, 16'd511);
      repeat (10) applyStimulus(1'b1, 1'b0, '0);

      // Redirect to 4 with a pop and an ack landing in the same ISSUE cycle.
      forceLat = 0;
      repeat (4) applyStimulus(1'b1, 1'b0, '0);
      strayAck = 1'b1;
      applyStimulus(1'b1, 1'b1, 16'd4);
      strayAck = 1'b0;
      repeat (4) applyStimulus(1'b1, 1'b0, '0);

      // Fetch across the top of the address space.
      applyStimulus(1'b1, 1'b1, 16'hFFFE);
      repeat (6) applyStimulus(1'b1, 1'b0, '0);

      // Randomised traffic with one reset in the middle.
      forceLat = -1;
      for (int i = 0; i < 600; i++) begin
         if (i == 300) applyReset();
         applyStimulus(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                       16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
